// File: rtl/soc_system_fifo_pkg.sv
// Shared definitions for the fabric<->HPS packet FIFOs: packet-info bit layout
// and the stream/MM byte-order helper.
package soc_system_fifo_pkg;

    localparam int DATA_W         = 32;
    localparam int INFO_SOP       = 0;
    localparam int INFO_EOP       = 1;
    localparam int INFO_EMPTY_LSB = 2;
    localparam int INFO_EMPTY_MSB = 3;
    localparam int INFO_VALID     = 4;
    localparam int INFO_W         = 4;
    localparam int ENTRY_W        = DATA_W + INFO_W;

    // Stream byte 0 sits in [31:24]; the HPS expects byte 0 in [7:0].
    function automatic logic [31:0] byte_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/soc_system_fifo_h2f_out_if.sv
// Avalon-ST sink plus Avalon-MM read slave signals of the fabric-to-HPS FIFO.
// slave = FIFO side, master = fabric source / HPS reader side.
import soc_system_fifo_pkg::*;

interface soc_system_fifo_h2f_out_if;
    logic [DATA_W-1:0] avalonst_sink_data;
    logic              avalonst_sink_valid;
    logic              avalonst_sink_ready;
    logic              avalonst_sink_startofpacket;
    logic              avalonst_sink_endofpacket;
    logic [1:0]        avalonst_sink_empty;
    logic              avalonmm_read_slave_address;
    logic              avalonmm_read_slave_read;
    logic [DATA_W-1:0] avalonmm_read_slave_readdata;
    logic              avalonmm_read_slave_waitrequest;

    modport slave (
        input  avalonst_sink_data, avalonst_sink_valid, avalonst_sink_startofpacket,
               avalonst_sink_endofpacket, avalonst_sink_empty,
               avalonmm_read_slave_address, avalonmm_read_slave_read,
        output avalonst_sink_ready, avalonmm_read_slave_readdata,
               avalonmm_read_slave_waitrequest
    );

    modport master (
        output avalonst_sink_data, avalonst_sink_valid, avalonst_sink_startofpacket,
               avalonst_sink_endofpacket, avalonst_sink_empty,
               avalonmm_read_slave_address, avalonmm_read_slave_read,
        input  avalonst_sink_ready, avalonmm_read_slave_readdata,
               avalonmm_read_slave_waitrequest
    );
endinterface

// File: rtl/soc_system_fifo_sync_core.sv
// Generic single-clock show-ahead FIFO. The head entry is always presented on
// rdata_o; pop_i only advances it. Push at full and pop at empty are ignored.
import soc_system_fifo_pkg::*;

module soc_system_fifo_sync_core #(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next state; pointers wrap naturally since DEPTH is 2^AW.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset empties the FIFO regardless of storage contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are only meaningful below count, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/soc_system_fifo_h2f_out.sv
// Fabric-to-HPS packet FIFO: Avalon-ST sink in, Avalon-MM read slave out.
// Address 0 pops byte-swapped data, address 1 peeks the head's packet info.
import soc_system_fifo_pkg::*;

module soc_system_fifo_h2f_out #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                       rdclock,
    input  logic                       reset_n,
    soc_system_fifo_h2f_out_if.slave   bus
);

    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] wentry;
    logic               fifo_full, fifo_empty;
    logic [AW:0]        fifo_count;
    logic               push, rd_accept, pop, head_valid;
    logic [DATA_W-1:0]  info_word;
    logic [DATA_W-1:0]  readdata_q, readdata_d;

    assign wentry = {bus.avalonst_sink_empty, bus.avalonst_sink_endofpacket,
                     bus.avalonst_sink_startofpacket, bus.avalonst_sink_data};

    assign bus.avalonst_sink_ready = reset_n && !fifo_full;
    assign push = bus.avalonst_sink_valid && bus.avalonst_sink_ready;

    assign bus.avalonmm_read_slave_waitrequest = !reset_n ||
        (bus.avalonmm_read_slave_read && !bus.avalonmm_read_slave_address && fifo_empty);
    assign rd_accept = bus.avalonmm_read_slave_read && !bus.avalonmm_read_slave_waitrequest;
    assign pop       = rd_accept && !bus.avalonmm_read_slave_address;

    assign head_valid = (fifo_count != '0);
    assign bus.avalonmm_read_slave_readdata = readdata_q;

    soc_system_fifo_sync_core #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_core (
        .clk     (rdclock),
        .rst_n   (reset_n),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Info word of the head entry; forced to zero when nothing is stored.
    always_comb begin
        info_word = '0;
        if (head_valid) begin
            info_word[INFO_VALID]                     = 1'b1;
            info_word[INFO_EMPTY_MSB:INFO_SOP]        = head[ENTRY_W-1:DATA_W];
        end
    end

    // Read result selection; held between accepted reads.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_accept) begin
            if (!bus.avalonmm_read_slave_address) readdata_d = byte_swap32(head[DATA_W-1:0]);
            else                                  readdata_d = info_word;
        end
    end

    // Registered read data gives the fixed one-cycle read latency.
    always_ff @(posedge rdclock or negedge reset_n) begin
        if (!reset_n) readdata_q <= '0;
        else          readdata_q <= readdata_d;
    end

endmodule

// File: tb/tb_soc_system_fifo_h2f_out.sv
module tb_soc_system_fifo_h2f_out;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    soc_system_fifo_h2f_out_if bus();

    soc_system_fifo_h2f_out #(.DEPTH(DEPTH), .AW(3)) dut (
        .rdclock (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of {empty,eop,sop,data} words and the expected read result.
    logic [35:0] mq[$];
    logic [31:0] m_rd = '0;

    function automatic logic [31:0] swap_ref(input logic [31:0] d);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(3-b) +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin : model
        bit acc, psh;
        logic [35:0] h;
        if (!reset_n) begin
            mq.delete();
            m_rd = '0;
        end else begin
            psh = bus.avalonst_sink_valid && (mq.size() < DEPTH);
            acc = bus.avalonmm_read_slave_read &&
                  !(!bus.avalonmm_read_slave_address && mq.size() == 0);
            if (acc) begin
                if (!bus.avalonmm_read_slave_address) begin
                    h = mq.pop_front();
                    m_rd = swap_ref(h[31:0]);
                end else if (mq.size() == 0) begin
                    m_rd = '0;
                end else begin
                    m_rd = {27'd0, 1'b1, mq[0][35:32]};
                end
            end
            if (psh) mq.push_back({bus.avalonst_sink_empty, bus.avalonst_sink_endofpacket,
                                   bus.avalonst_sink_startofpacket, bus.avalonst_sink_data});
        end
    end

    always @(negedge clk) begin : compare
        chk("ready", {31'd0, bus.avalonst_sink_ready}, {31'd0, reset_n && (mq.size() < DEPTH)});
        chk("waitrequest", {31'd0, bus.avalonmm_read_slave_waitrequest},
            {31'd0, !reset_n || (bus.avalonmm_read_slave_read &&
                                 !bus.avalonmm_read_slave_address && mq.size() == 0)});
        chk("readdata", bus.avalonmm_read_slave_readdata, m_rd);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input bit rd, input bit addr);
        bus.avalonmm_read_slave_read    = rd;
        bus.avalonmm_read_slave_address = addr;
    endtask

    task automatic push_word(input logic [31:0] d, input bit s, input bit e, input logic [1:0] emp);
        bit ok;
        ok = 1'b0;
        bus.avalonst_sink_valid         = 1'b1;
        bus.avalonst_sink_data          = d;
        bus.avalonst_sink_startofpacket = s;
        bus.avalonst_sink_endofpacket   = e;
        bus.avalonst_sink_empty         = emp;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = bus.avalonst_sink_ready;
            step();
        end
        bus.avalonst_sink_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: ready stayed %b expected 1", bus.avalonst_sink_ready);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.avalonst_sink_data          = 32'h0;
        bus.avalonst_sink_valid         = 1'b1;
        bus.avalonst_sink_startofpacket = 1'b0;
        bus.avalonst_sink_endofpacket   = 1'b0;
        bus.avalonst_sink_empty         = 2'd0;
        set_rd(1'b0, 1'b0);

        // 1: reset with valid asserted
        reset_n = 1'b0;
        repeat (3) step();
        chk("rst_ready", {31'd0, bus.avalonst_sink_ready}, 32'd0);
        chk("rst_wait", {31'd0, bus.avalonmm_read_slave_waitrequest}, 32'd1);
        chk("rst_readdata", bus.avalonmm_read_slave_readdata, 32'd0);
        bus.avalonst_sink_valid = 1'b0;
        reset_n = 1'b1;
        step();
        chk("post_rst_ready", {31'd0, bus.avalonst_sink_ready}, 32'd1);
        set_rd(1'b1, 1'b1);
        step();
        chk("post_rst_info", bus.avalonmm_read_slave_readdata, 32'h0);
        set_rd(1'b0, 1'b0);

        // 2: single packet
        push_word(32'h11223344, 1'b1, 1'b0, 2'd0);
        push_word(32'h55667788, 1'b0, 1'b1, 2'd2);
        set_rd(1'b1, 1'b1); step(); chk("pkt_info0", bus.avalonmm_read_slave_readdata, 32'h11);
        set_rd(1'b1, 1'b0); step(); chk("pkt_data0", bus.avalonmm_read_slave_readdata, 32'h44332211);
        set_rd(1'b1, 1'b1); step(); chk("pkt_info1", bus.avalonmm_read_slave_readdata, 32'h1A);
        set_rd(1'b1, 1'b0); step(); chk("pkt_data1", bus.avalonmm_read_slave_readdata, 32'h88776655);
        set_rd(1'b1, 1'b1); step(); chk("pkt_info_empty", bus.avalonmm_read_slave_readdata, 32'h0);
        set_rd(1'b0, 1'b0);

        // 3: fill past full
        for (int i = 0; i < 8; i++) push_word(32'h0A0B0C00 + i, i == 0, 1'b0, 2'd0);
        chk("full_ready", {31'd0, bus.avalonst_sink_ready}, 32'd0);
        bus.avalonst_sink_valid = 1'b1;
        bus.avalonst_sink_data  = 32'h0A0B0C08;
        bus.avalonst_sink_endofpacket = 1'b1;
        step(); step();
        chk("full_hold_ready", {31'd0, bus.avalonst_sink_ready}, 32'd0);
        set_rd(1'b1, 1'b0); step();
        chk("full_pop_data", bus.avalonmm_read_slave_readdata, 32'h000C0B0A);
        set_rd(1'b0, 1'b0);
        chk("after_pop_ready", {31'd0, bus.avalonst_sink_ready}, 32'd1);
        step();
        bus.avalonst_sink_valid = 1'b0;
        bus.avalonst_sink_endofpacket = 1'b0;
        set_rd(1'b1, 1'b0);
        repeat (8) step();
        chk("drain_last", bus.avalonmm_read_slave_readdata, 32'h080C0B0A);
        set_rd(1'b0, 1'b0);

        // 4: stalled read completes after a push
        set_rd(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_wait", {31'd0, bus.avalonmm_read_slave_waitrequest}, 32'd1);
        end
        bus.avalonst_sink_valid = 1'b1;
        bus.avalonst_sink_data  = 32'hA5A5A5A5;
        step();
        bus.avalonst_sink_valid = 1'b0;
        chk("stall_release", {31'd0, bus.avalonmm_read_slave_waitrequest}, 32'd0);
        step();
        chk("stall_data", bus.avalonmm_read_slave_readdata, 32'hA5A5A5A5);
        set_rd(1'b0, 1'b0);

        // 5: concurrent push/pop at half full
        for (int i = 0; i < 4; i++) push_word($urandom, 1'b0, 1'b0, 2'd0);
        bus.avalonst_sink_valid = 1'b1;
        set_rd(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            bus.avalonst_sink_data          = $urandom;
            bus.avalonst_sink_startofpacket = 1'($urandom_range(0, 1));
            bus.avalonst_sink_endofpacket   = 1'($urandom_range(0, 1));
            bus.avalonst_sink_empty         = 2'($urandom_range(0, 3));
            step();
            if (i % 25 == 0) chk("conc_level", mq.size(), 32'd4);
        end
        bus.avalonst_sink_valid = 1'b0;
        set_rd(1'b0, 1'b0);

        // random mix
        for (int i = 0; i < 400; i++) begin
            bus.avalonst_sink_valid         = 1'($urandom_range(0, 1));
            bus.avalonst_sink_data          = $urandom;
            bus.avalonst_sink_startofpacket = 1'($urandom_range(0, 1));
            bus.avalonst_sink_endofpacket   = 1'($urandom_range(0, 1));
            bus.avalonst_sink_empty         = 2'($urandom_range(0, 3));
            set_rd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        bus.avalonst_sink_valid = 1'b0;
        set_rd(1'b1, 1'b0);
        for (int k = 0; k < 20 && mq.size() != 0; k++) step();
        set_rd(1'b0, 1'b0);
        step();

        // 6: reset mid-packet
        push_word(32'h01010101, 1'b1, 1'b0, 2'd0);
        push_word(32'h02020202, 1'b0, 1'b0, 2'd0);
        push_word(32'h03030303, 1'b0, 1'b0, 2'd0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        set_rd(1'b1, 1'b1); step();
        chk("mid_rst_info", bus.avalonmm_read_slave_readdata, 32'h0);
        set_rd(1'b1, 1'b0); step();
        chk("mid_rst_wait0", {31'd0, bus.avalonmm_read_slave_waitrequest}, 32'd1);
        step();
        chk("mid_rst_wait1", {31'd0, bus.avalonmm_read_slave_waitrequest}, 32'd1);
        bus.avalonst_sink_valid = 1'b1;
        bus.avalonst_sink_data  = 32'hDEADBEEF;
        step();
        bus.avalonst_sink_valid = 1'b0;
        step();
        chk("mid_rst_data", bus.avalonmm_read_slave_readdata, 32'hEFBEADDE);
        set_rd(1'b0, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
